// File: rtl/rob_commit_unit.sv
// Reorder buffer commit side: allocates up to 4 entries per cycle, captures forwarded results,
// and retires up to 2 ready entries per cycle in order, with flush on mispredict and sticky halt.
module rob_commit_unit #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       alloc_valid,
  input  logic [63:0]      alloc_pc,
  input  logic [11:0]      alloc_dest,
  input  logic [3:0]       alloc_wr_reg,
  input  logic [3:0]       alloc_is_store,
  input  logic [3:0]       alloc_is_halt,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_tail,
  input  logic [22:0]      forwardA,
  input  logic [22:0]      forwardB,
  input  logic [22:0]      forwardC,
  input  logic [22:0]      forwardD,
  input  logic             br_valid,
  input  logic [IDX_W-1:0] br_rob,
  input  logic             br_mispredict,
  input  logic [15:0]      br_target,
  output logic             wen0,
  output logic [2:0]       waddr0,
  output logic [15:0]      wdata0,
  output logic             wen1,
  output logic [2:0]       waddr1,
  output logic [15:0]      wdata1,
  output logic [1:0]       stores_to_commit,
  output logic             flush,
  output logic [15:0]      flush_pc,
  output logic             halted,
  output logic [IDX_W:0]   rob_count
);

  localparam int unsigned CntW = IDX_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, mispred_q, mispred_d;
  logic [DEPTH-1:0] wr_reg_q, wr_reg_d, is_store_q, is_store_d, is_halt_q, is_halt_d;
  logic [15:0]      value_q  [DEPTH];
  logic [15:0]      value_d  [DEPTH];
  logic [15:0]      target_q [DEPTH];
  logic [15:0]      target_d [DEPTH];
  logic [2:0]       dest_q   [DEPTH];
  logic [2:0]       dest_d   [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [CntW-1:0]  count_q, count_d, n_alloc;
  logic [1:0]       n_ret;
  logic             halted_q, halted_d;
  logic             ret0, ret1, do_flush, alloc_go;

  logic             wen0_d, wen1_d, flush_d;
  logic [2:0]       waddr0_d, waddr1_d;
  logic [15:0]      wdata0_d, wdata1_d, flush_pc_d;
  logic [1:0]       stores_d;

  logic [22:0]      fwd [4];
  logic             unused_pc;

  assign unused_pc = ^alloc_pc;
  assign fwd[0] = forwardA;
  assign fwd[1] = forwardB;
  assign fwd[2] = forwardC;
  assign fwd[3] = forwardD;

  assign head1    = head_q + IDX_W'(1);
  assign ret0     = !halted_q && busy_q[head_q] && ready_q[head_q];
  // A mispredicted branch or HALT in slot 0 ends the retire group.
  assign ret1     = ret0 && !mispred_q[head_q] && !is_halt_q[head_q] &&
                    busy_q[head1] && ready_q[head1];
  assign do_flush = ret0 && mispred_q[head_q];

  assign alloc_ready = (count_q <= CntW'(DEPTH - 4)) && !halted_q;
  assign alloc_go    = alloc_ready && !do_flush;
  assign alloc_tail  = tail_q;
  assign rob_count   = count_q;
  assign halted      = halted_q;

  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    mispred_d  = mispred_q;
    wr_reg_d   = wr_reg_q;
    is_store_d = is_store_q;
    is_halt_d  = is_halt_q;
    value_d    = value_q;
    target_d   = target_q;
    dest_d     = dest_q;
    n_alloc    = '0;
    n_ret      = {1'b0, ret0} + {1'b0, ret1};

    if (alloc_go) begin
      for (int i = 0; i < 4; i++) begin
        if (alloc_valid[i]) begin
          busy_d[tail_q + IDX_W'(i)]     = 1'b1;
          ready_d[tail_q + IDX_W'(i)]    = 1'b0;
          mispred_d[tail_q + IDX_W'(i)]  = 1'b0;
          wr_reg_d[tail_q + IDX_W'(i)]   = alloc_wr_reg[i];
          is_store_d[tail_q + IDX_W'(i)] = alloc_is_store[i];
          is_halt_d[tail_q + IDX_W'(i)]  = alloc_is_halt[i];
          dest_d[tail_q + IDX_W'(i)]     = alloc_dest[3*i +: 3];
          n_alloc                        = n_alloc + CntW'(1);
        end
      end
    end

    // Later lanes overwrite earlier ones, so lane D wins on a shared index.
    for (int i = 0; i < 4; i++) begin
      if (fwd[i][22] && busy_q[fwd[i][16 +: IDX_W]]) begin
        ready_d[fwd[i][16 +: IDX_W]] = 1'b1;
        value_d[fwd[i][16 +: IDX_W]] = fwd[i][15:0];
      end
    end

    if (br_valid && busy_q[br_rob]) begin
      ready_d[br_rob]   = 1'b1;
      mispred_d[br_rob] = br_mispredict;
      target_d[br_rob]  = br_target;
    end

    if (ret0) busy_d[head_q] = 1'b0;
    if (ret1) busy_d[head1]  = 1'b0;

    head_d   = head_q + IDX_W'(n_ret);
    tail_d   = tail_q + IDX_W'(n_alloc);
    count_d  = count_q + n_alloc - CntW'(n_ret);
    halted_d = halted_q | (ret0 & is_halt_q[head_q]) | (ret1 & is_halt_q[head1]);

    if (do_flush) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    wen0_d     = ret0 & wr_reg_q[head_q] &
                 ~(ret1 & wr_reg_q[head1] & (dest_q[head1] == dest_q[head_q]));
    wen1_d     = ret1 & wr_reg_q[head1];
    waddr0_d   = ret0 ? dest_q[head_q] : '0;
    wdata0_d   = ret0 ? value_q[head_q] : '0;
    waddr1_d   = ret1 ? dest_q[head1] : '0;
    wdata1_d   = ret1 ? value_q[head1] : '0;
    stores_d   = {1'b0, ret0 & is_store_q[head_q]} + {1'b0, ret1 & is_store_q[head1]};
    flush_d    = do_flush;
    flush_pc_d = do_flush ? target_q[head_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q           <= '0;
      ready_q          <= '0;
      mispred_q        <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      halted_q         <= 1'b0;
      wen0             <= 1'b0;
      waddr0           <= '0;
      wdata0           <= '0;
      wen1             <= 1'b0;
      waddr1           <= '0;
      wdata1           <= '0;
      stores_to_commit <= '0;
      flush            <= 1'b0;
      flush_pc         <= '0;
    end else begin
      busy_q           <= busy_d;
      ready_q          <= ready_d;
      mispred_q        <= mispred_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      halted_q         <= halted_d;
      wen0             <= wen0_d;
      waddr0           <= waddr0_d;
      wdata0           <= wdata0_d;
      wen1             <= wen1_d;
      waddr1           <= waddr1_d;
      wdata1           <= wdata1_d;
      stores_to_commit <= stores_d;
      flush            <= flush_d;
      flush_pc         <= flush_pc_d;
    end
  end

  // Payload is only read under busy, so it needs no reset.
  always_ff @(posedge clk) begin
    wr_reg_q   <= wr_reg_d;
    is_store_q <= is_store_d;
    is_halt_q  <= is_halt_d;
    value_q    <= value_d;
    target_q   <= target_d;
    dest_q     <= dest_d;
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: in-order dual retire, flush, full/wrap, stores and halt.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alloc_valid, alloc_wr_reg, alloc_is_store, alloc_is_halt;
  logic [63:0] alloc_pc;
  logic [11:0] alloc_dest;
  logic        alloc_ready;
  logic [5:0]  alloc_tail;
  logic [22:0] fa, fb, fc, fd;
  logic        br_valid, br_mispredict;
  logic [5:0]  br_rob;
  logic [15:0] br_target;
  logic        wen0, wen1, flush, halted;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1, flush_pc;
  logic [1:0]  stores_to_commit;
  logic [6:0]  rob_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_dest(alloc_dest),
    .alloc_wr_reg(alloc_wr_reg), .alloc_is_store(alloc_is_store), .alloc_is_halt(alloc_is_halt),
    .alloc_ready(alloc_ready), .alloc_tail(alloc_tail),
    .forwardA(fa), .forwardB(fb), .forwardC(fc), .forwardD(fd),
    .br_valid(br_valid), .br_rob(br_rob), .br_mispredict(br_mispredict), .br_target(br_target),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .stores_to_commit(stores_to_commit), .flush(flush), .flush_pc(flush_pc),
    .halted(halted), .rob_count(rob_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid    = '0;
    alloc_wr_reg   = '0;
    alloc_is_store = '0;
    alloc_is_halt  = '0;
    alloc_dest     = '0;
    fa = '0; fb = '0; fc = '0; fd = '0;
    br_valid = 1'b0; br_mispredict = 1'b0; br_rob = '0; br_target = '0;
  endtask

  function automatic logic [22:0] fw(input logic [5:0] idx, input logic [15:0] val);
    return {1'b1, idx, val};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    alloc_pc = 64'h0040_0030_0020_0010;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_count", rob_count, 0);
    chk("reset_ready", alloc_ready, 1);
    chk("reset_tail", alloc_tail, 0);
    chk("reset_outs", {wen0, wen1, flush, halted, stores_to_commit}, 0);

    // 1: four allocs, all forwarded together, retire two per cycle
    alloc_valid = 4'hF; alloc_wr_reg = 4'hF; alloc_dest = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    idle();
    chk("t1_tail", alloc_tail, 4);
    chk("t1_count", rob_count, 4);
    fa = fw(6'd0, 16'd10); fb = fw(6'd1, 16'd20); fc = fw(6'd2, 16'd30); fd = fw(6'd3, 16'd40);
    tick();
    idle();
    chk("t1_nocommit_yet", {wen0, wen1}, 0);
    tick();
    chk("t1_port0", {wen0, waddr0, wdata0}, {1'b1, 3'd1, 16'd10});
    chk("t1_port1", {wen1, waddr1, wdata1}, {1'b1, 3'd2, 16'd20});
    chk("t1_count_mid", rob_count, 2);
    tick();
    chk("t1_port0_b", {wen0, waddr0, wdata0}, {1'b1, 3'd3, 16'd30});
    chk("t1_port1_b", {wen1, waddr1, wdata1}, {1'b1, 3'd4, 16'd40});
    chk("t1_count_end", rob_count, 0);

    // 2: younger ready first; later the head gets two same-index writebacks (lane D wins)
    alloc_valid = 4'b0011; alloc_wr_reg = 4'b0011; alloc_dest = {3'd0, 3'd0, 3'd7, 3'd6};
    tick();
    idle();
    fb = fw(6'd5, 16'h0055);
    tick();
    idle();
    tick();
    chk("t2_held", {wen0, wen1}, 0);
    chk("t2_count_held", rob_count, 2);
    fa = fw(6'd4, 16'h0044); fd = fw(6'd4, 16'h0099);
    tick();
    idle();
    tick();
    chk("t2_port0", {wen0, waddr0, wdata0}, {1'b1, 3'd6, 16'h0099});
    chk("t2_port1", {wen1, waddr1, wdata1}, {1'b1, 3'd7, 16'h0055});
    chk("t2_count_end", rob_count, 0);

    // 3: mispredicted branch at head (entry 6), younger entries ready behind it
    alloc_valid = 4'hF; alloc_wr_reg = 4'b1110; alloc_dest = {3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    idle();
    fb = fw(6'd7, 16'h0777); fc = fw(6'd8, 16'h0888); fd = fw(6'd9, 16'h0999);
    br_valid = 1'b1; br_rob = 6'd6; br_mispredict = 1'b1; br_target = 16'h0040;
    tick();
    idle();
    alloc_valid = 4'b0001;
    tick();
    idle();
    chk("t3_flush", {flush, flush_pc}, {1'b1, 16'h0040});
    chk("t3_no_wen", {wen0, wen1}, 0);
    chk("t3_count", rob_count, 0);
    chk("t3_tail", alloc_tail, 0);
    tick();
    chk("t3_flush_gone", flush, 0);
    chk("t3_younger_squashed", {wen0, wen1, rob_count}, 0);

    // 4: fill to 61, blocked alloc, retire one, refill across the wrap
    for (int k = 0; k < 15; k++) begin
      alloc_valid = 4'hF;
      tick();
    end
    alloc_valid = 4'b0001;
    tick();
    chk("t4_count61", rob_count, 61);
    chk("t4_not_ready", alloc_ready, 0);
    alloc_valid = 4'hF;
    tick();
    idle();
    chk("t4_blocked_count", rob_count, 61);
    chk("t4_blocked_tail", alloc_tail, 61);
    fa = fw(6'd0, 16'h0abc);
    tick();
    idle();
    tick();
    chk("t4_count60", rob_count, 60);
    chk("t4_ready_again", alloc_ready, 1);
    alloc_valid = 4'hF; alloc_wr_reg = 4'hF; alloc_dest = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    idle();
    chk("t4_tail_wrap", alloc_tail, 1);
    chk("t4_full", {alloc_ready, rob_count}, {1'b0, 7'd64});
    for (int k = 0; k < 16; k++) begin
      fa = fw(6'(4 * k),     16'(16'h0100 + 4 * k));
      fb = fw(6'(4 * k + 1), 16'(16'h0101 + 4 * k));
      fc = fw(6'(4 * k + 2), 16'(16'h0102 + 4 * k));
      fd = fw(6'(4 * k + 3), 16'(16'h0103 + 4 * k));
      tick();
    end
    idle();
    n = 0;
    while (wen0 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_wrap_port0", {wen0, waddr0, wdata0}, {1'b1, 3'd1, 16'h013d});
    chk("t4_wrap_port1", {wen1, waddr1, wdata1}, {1'b1, 3'd2, 16'h013e});
    tick();
    chk("t4_wrap_port0_b", {wen0, waddr0, wdata0}, {1'b1, 3'd3, 16'h013f});
    chk("t4_wrap_port1_b", {wen1, waddr1, wdata1}, {1'b1, 3'd4, 16'h0100});
    chk("t4_drained", rob_count, 0);

    // 5: two stores to r5 at entries 1,2
    alloc_valid = 4'b0011; alloc_wr_reg = 4'b0011; alloc_is_store = 4'b0011;
    alloc_dest = {3'd0, 3'd0, 3'd5, 3'd5};
    tick();
    idle();
    fa = fw(6'd1, 16'haaaa); fb = fw(6'd2, 16'hbbbb);
    tick();
    idle();
    tick();
    chk("t5_stores", stores_to_commit, 2);
    chk("t5_wen0_masked", wen0, 0);
    chk("t5_port1", {wen1, waddr1, wdata1}, {1'b1, 3'd5, 16'hbbbb});

    // 6: HALT at entry 3 with a ready younger entry at 4
    alloc_valid = 4'b0011; alloc_wr_reg = 4'b0010; alloc_is_halt = 4'b0001;
    alloc_dest = {3'd0, 3'd0, 3'd6, 3'd0};
    tick();
    idle();
    fa = fw(6'd3, 16'h0000); fb = fw(6'd4, 16'h0066);
    tick();
    idle();
    tick();
    chk("t6_halted", halted, 1);
    chk("t6_no_wen", {wen0, wen1}, 0);
    chk("t6_alloc_ready", alloc_ready, 0);
    chk("t6_count", rob_count, 1);
    alloc_valid = 4'b0001;
    tick();
    idle();
    chk("t6_alloc_ignored", rob_count, 1);
    tick();
    chk("t6_still_quiet", {wen0, wen1, halted}, {1'b0, 1'b0, 1'b1});

    // Reset mid-operation dominates live inputs
    reset = 1'b1;
    alloc_valid = 4'hF; fa = fw(6'd4, 16'h1234);
    tick();
    reset = 1'b0;
    idle();
    chk("rst2_state", {halted, rob_count, alloc_tail}, 0);
    chk("rst2_ready", alloc_ready, 1);
    chk("rst2_outs", {wen0, wen1, flush, stores_to_commit}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
